// File: rtl/data_io_block_pkg.sv
// Shared sizing helpers for the I/O tile: config vector width and the
// offsets of the input-drive and output-select fields inside it.
package data_io_block_pkg;

   function automatic int cw(input int w, input int n_in, input int n_out);
      return w * (n_in + n_out);
   endfunction

   function automatic int in_off(input int w, input int i);
      return i * w;
   endfunction

   // Output-select fields sit after all input fields.
   function automatic int out_off(input int w, input int n_in, input int i);
      return (n_in + i) * w;
   endfunction

endpackage

// File: rtl/data_io_out_bit.sv
// One external output pin: priority select over its candidate tracks,
// falling back to the last captured value when nothing is selected.
module data_io_out_bit #(
   parameter int NC = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [NC-1:0] tracks,
   input  logic [NC-1:0] sel,
   output logic          q
);

   logic active;
   logic val;
   logic hold_q;

   assign active = |sel;

   // Scan from the top so the lowest selected candidate is assigned last and wins.
   always_comb begin
      val = 1'b0;
      for (int k = NC - 1; k >= 0; k--) begin
         if (sel[k]) val = tracks[k];
      end
   end

   assign q = active ? val : hold_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         hold_q <= 1'b0;
      else if (active) hold_q <= val;
   end

endmodule

// File: rtl/data_io_block.sv
// Fabric-edge I/O tile: config bits route external input pins onto the
// tri-state track bus and tap tracks onto the external output pins.
module data_io_block
   import data_io_block_pkg::*;
#(
   parameter int W          = 12,
   parameter int WW         = 4,
   parameter int EXTDATAIN  = 3,
   parameter int EXTDATAOUT = 2
) (
   input  logic                                  clk,
   input  logic                                  rst,
   inout  wire  [W-1:0]                          data,
   input  logic [WW*EXTDATAIN-1:0]               external_input,
   output logic [WW*EXTDATAOUT-1:0]              external_output,
   input  logic [cw(W,EXTDATAIN,EXTDATAOUT)-1:0] c
);

   localparam int NC = W / WW;

   logic [W-1:0] drv_en;
   logic [W-1:0] drv_val;

   // Lowest-numbered port with its select set owns the track.
   always_comb begin
      drv_en  = '0;
      drv_val = '0;
      for (int j = 0; j < W; j++) begin
         for (int i = EXTDATAIN - 1; i >= 0; i--) begin
            if (c[in_off(W, i) + j]) begin
               drv_en[j]  = 1'b1;
               drv_val[j] = external_input[i*WW + (j % WW)];
            end
         end
      end
   end

   for (genvar j = 0; j < W; j++) begin : g_drv
      assign data[j] = drv_en[j] ? drv_val[j] : 1'bz;
   end

   // Output bit b of every port sees tracks b, b+WW, b+2*WW, ...
   for (genvar i = 0; i < EXTDATAOUT; i++) begin : g_port
      for (genvar b = 0; b < WW; b++) begin : g_bit
         logic [NC-1:0] trk;
         logic [NC-1:0] sel;
         for (genvar k = 0; k < NC; k++) begin : g_cand
            assign trk[k] = data[k*WW + b];
            assign sel[k] = c[out_off(W, EXTDATAIN, i) + k*WW + b];
         end
         data_io_out_bit #(.NC(NC)) u_bit (
            .clk    (clk),
            .rst    (rst),
            .tracks (trk),
            .sel    (sel),
            .q      (external_output[i*WW + b])
         );
      end
   end

endmodule

// File: tb/tb_data_io_block.sv
// Self-checking bench for data_io_block: directed pin-map cases plus
// randomized config/data against a pin-level routing model.
module tb_data_io_block;

   localparam int W   = 12;
   localparam int WW  = 4;
   localparam int EIN = 3;
   localparam int EOUT = 2;
   localparam int CW  = W * (EIN + EOUT);
   localparam int OW  = WW * EOUT;

   logic           clk;
   logic           rst;
   wire  [W-1:0]   data;
   logic [WW*EIN-1:0] ext_in;
   logic [OW-1:0]  ext_out;
   logic [CW-1:0]  c;

   logic [W-1:0]   tb_en;
   logic [W-1:0]   tb_drv;
   logic [OW-1:0]  hold_m;
   logic           check_en;
   int             vectors;
   int             miscompares;

   for (genvar j = 0; j < W; j++) begin : g_tbdrv
      assign data[j] = tb_en[j] ? tb_drv[j] : 1'bz;
   end

   data_io_block #(.W(W), .WW(WW), .EXTDATAIN(EIN), .EXTDATAOUT(EOUT)) dut (
      .clk             (clk),
      .rst             (rst),
      .data            (data),
      .external_input  (ext_in),
      .external_output (ext_out),
      .c               (c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Value a track should carry: first port that selects it, else the bench, else nobody.
   function automatic logic mdl_track(input int j);
      for (int i = 0; i < EIN; i++)
         if (c[i*W + j]) return ext_in[i*WW + (j % WW)];
      if (tb_en[j]) return tb_drv[j];
      return 1'bz;
   endfunction

   function automatic logic [W-1:0] mdl_bus();
      logic [W-1:0] r;
      for (int j = 0; j < W; j++) r[j] = mdl_track(j);
      return r;
   endfunction

   function automatic logic [OW-1:0] mdl_out();
      logic [OW-1:0] r;
      logic found;
      for (int i = 0; i < EOUT; i++) begin
         for (int b = 0; b < WW; b++) begin
            r[i*WW + b] = hold_m[i*WW + b];
            found = 1'b0;
            for (int j = 0; j < W; j++) begin
               if (!found && (j % WW) == b && c[EIN*W + i*W + j]) begin
                  r[i*WW + b] = mdl_track(j);
                  found = 1'b1;
               end
            end
         end
      end
      return r;
   endfunction

   // Tracks driven by some input port, used to keep the bench off them.
   function automatic logic [W-1:0] in_mask();
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < EIN; i++)
         for (int j = 0; j < W; j++)
            if (c[i*W + j]) r[j] = 1'b1;
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) hold_m <= '0;
      else     hold_m <= mdl_out();
   end

   always @(negedge clk) begin
      if (check_en) begin
         logic [W-1:0]  ed;
         logic [OW-1:0] eo;
         ed = mdl_bus();
         eo = mdl_out();
         vectors++;
         if (data !== ed) begin
            miscompares++;
            $display("FAIL bus @%0t: data got %b want %b (c=%h)", $time, data, ed, c);
         end
         vectors++;
         if (ext_out !== eo) begin
            miscompares++;
            $display("FAIL out @%0t: external_output got %b want %b (c=%h)", $time, ext_out, eo, c);
         end
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] all_z;
      all_z       = 'z;
      vectors     = 0;
      miscompares = 0;
      check_en    = 1'b0;
      rst         = 1'b1;
      c           = '0;
      ext_in      = '0;
      tb_en       = '0;
      tb_drv      = '0;
      #12;
      chk("reset_out", 16'(ext_out), 16'h0000);
      chk("reset_bus_z", {4'h0, data}, {4'h0, all_z});
      cyc();
      rst      = 1'b0;
      check_en = 1'b1;

      // Input drive sweep
      ext_in = 12'hA5C;
      for (int i = 0; i < EIN; i++) begin
         for (int j = 0; j < W; j++) begin
            c = '0;
            c[i*W + j] = 1'b1;
            cyc();
         end
      end
      c = '0;
      c[2*W + 3] = 1'b1;
      #1;
      chk("in_p2_t3", 16'(data[3]), 16'h1);

      // Output select sweep with the bench driving the whole bus
      c      = '0;
      tb_en  = '1;
      tb_drv = 12'h3B7;
      for (int i = 0; i < EOUT; i++) begin
         for (int j = 0; j < W; j++) begin
            c = '0;
            c[EIN*W + i*W + j] = 1'b1;
            cyc();
         end
      end
      c = '0;
      c[EIN*W + W + 9] = 1'b1;
      #1;
      chk("out_p1_t9", 16'(ext_out[5]), 16'h1);

      // Hold after deselect, then async clear
      cyc();
      c = '0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      c[EIN*W + 5] = 1'b1;
      cyc();
      c = '0;
      #1;
      chk("hold_after_clear", 16'(ext_out[1]), 16'h1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_out", 16'(ext_out), 16'h0000);
      cyc();
      rst = 1'b0;

      // Input priority: lowest port wins
      tb_en  = '0;
      c      = '0;
      c[1]   = 1'b1;
      c[13]  = 1'b1;
      ext_in = 12'h0F2;
      #1;
      chk("in_prio_0F2", 16'(data[1]), 16'h1);
      ext_in = 12'h0D2;
      #1;
      chk("in_prio_0D2", 16'(data[1]), 16'h1);
      ext_in = 12'h020;
      #1;
      chk("in_prio_020", 16'(data[1]), 16'h0);
      cyc();

      // Output priority: lowest track wins
      c      = '0;
      tb_en  = '1;
      tb_drv = 12'h040;
      c[EIN*W + 2] = 1'b1;
      c[EIN*W + 6] = 1'b1;
      #1;
      chk("out_prio", 16'(ext_out[2]), 16'h0);
      cyc();

      // Randomized config, inputs and bus values; bench fills tracks the tile leaves free
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < CW; k++) c[k] = ($urandom_range(7) == 0);
         ext_in = 12'($urandom);
         tb_drv = 12'($urandom);
         tb_en  = ~in_mask();
         if ($urandom_range(49) == 0) rst = 1'b1;
         else                         rst = 1'b0;
         cyc();
      end
      rst = 1'b0;
      cyc();
      check_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
